burst_memory_slave: RTL and testbench



---
 rtl/burst_memory_slave.sv | 149 ++++++++++++++
 tb/tb_burst_memory_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memory_slave.sv
// On-chip Avalon-MM burst responder backed by a 2^ADDRESS_WIDTH-word RAM.
// Define BURST_MEMORY_SLAVE_BYTEENABLE_EN to honour slave_byteenable on writes.
module burst_memory_slave #(
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned ADDRESS_WIDTH       = 8,
  parameter int unsigned MAXIMUM_BURST_COUNT = 8,
  parameter int unsigned BURST_COUNT_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_WIDTH-1:0]     slave_address,
  input  logic                         slave_read,
  input  logic                         slave_write,
  input  logic [DATA_WIDTH/8-1:0]      slave_byteenable,
  input  logic [DATA_WIDTH-1:0]        slave_writedata,
  input  logic [BURST_COUNT_WIDTH-1:0] slave_burstcount,
  output logic [DATA_WIDTH-1:0]        slave_readdata,
  output logic                         slave_readdatavalid,
  output logic                         slave_waitrequest,
  input  logic                         control_clear_error,
  output logic                         status_busy,
  output logic                         status_protocol_error
);

  localparam int unsigned ByteW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(MAXIMUM_BURST_COUNT + 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [CntW-1:0]          remaining_q;
  logic [DATA_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];

  int unsigned              req_count;
  int unsigned              burst_n;
  logic                     wr_en;
  logic                     rd_en;
  logic                     violation;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [ADDRESS_WIDTH-1:0] rd_addr;

  always_comb begin
    req_count = 32'(slave_burstcount);
    if (req_count == 0) begin
      burst_n = 1;
    end else if (req_count > MAXIMUM_BURST_COUNT) begin
      burst_n = MAXIMUM_BURST_COUNT;
    end else begin
      burst_n = req_count;
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    violation = 1'b0;
    wr_addr   = slave_address;
    rd_addr   = slave_address;
    unique case (state_q)
      StIdle: begin
        // Simultaneous read and write: the write wins and the read is dropped.
        wr_en     = slave_write;
        rd_en     = slave_read & ~slave_write;
        violation = slave_read & slave_write;
      end
      StWrite: begin
        wr_en     = slave_write;
        wr_addr   = addr_q;
        violation = slave_read;
      end
      StRead: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
      end
      default: ;
    endcase
  end

  assign slave_waitrequest = reset | (state_q == StRead);
  assign status_busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= StIdle;
      addr_q                <= '0;
      remaining_q           <= '0;
      slave_readdatavalid   <= 1'b0;
      slave_readdata        <= '0;
      status_protocol_error <= 1'b0;
    end else begin
      slave_readdatavalid   <= rd_en;
      status_protocol_error <= violation | (status_protocol_error & ~control_clear_error);
      if (rd_en) begin
        slave_readdata <= mem[rd_addr];
      end
      unique case (state_q)
        StIdle: begin
          if (slave_write || slave_read) begin
            addr_q      <= slave_address + ADDRESS_WIDTH'(1);
            remaining_q <= CntW'(burst_n - 1);
            if (burst_n > 1) begin
              state_q <= slave_write ? StWrite : StRead;
            end
          end
        end
        StWrite: begin
          if (slave_write) begin
            addr_q      <= addr_q + ADDRESS_WIDTH'(1);
            remaining_q <= remaining_q - CntW'(1);
            if (remaining_q == CntW'(1)) begin
              state_q <= StIdle;
            end
          end
        end
        StRead: begin
          addr_q      <= addr_q + ADDRESS_WIDTH'(1);
          remaining_q <= remaining_q - CntW'(1);
          if (remaining_q == CntW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BURST_MEMORY_SLAVE_BYTEENABLE_EN
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < ByteW; b++) begin
        if (slave_byteenable[b]) begin
          mem[wr_addr][b*8 +: 8] <= slave_writedata[b*8 +: 8];
        end
      end
    end
  end
`else
  logic unused_byteenable;
  assign unused_byteenable = ^slave_byteenable;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= slave_writedata;
    end
  end
`endif

endmodule

// File: tb/tb_burst_memory_slave.sv
// Bench for burst_memory_slave: transaction-level memory model with a per-cycle compare,
// plus literal expectations for the key scenarios.
module tb_burst_memory_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [3:0]  slave_byteenable = '0;
  logic [31:0] slave_writedata = '0;
  logic [3:0]  slave_burstcount = '0;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        slave_waitrequest;
  logic        control_clear_error = 1'b0;
  logic        status_busy;
  logic        status_protocol_error;

  always #5 clk = ~clk;

  burst_memory_slave #(
    .DATA_WIDTH         (32),
    .ADDRESS_WIDTH      (8),
    .MAXIMUM_BURST_COUNT(8),
    .BURST_COUNT_WIDTH  (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_byteenable     (slave_byteenable),
    .slave_writedata      (slave_writedata),
    .slave_burstcount     (slave_burstcount),
    .slave_readdata       (slave_readdata),
    .slave_readdatavalid  (slave_readdatavalid),
    .slave_waitrequest    (slave_waitrequest),
    .control_clear_error  (control_clear_error),
    .status_busy          (status_busy),
    .status_protocol_error(status_protocol_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected outputs indexed by cycle number.
  bit          exp_valid [1024];
  bit          exp_wait  [1024];
  bit          exp_busy  [1024];
  bit          exp_err   [1024];
  logic [31:0] exp_data  [1024];

  logic [31:0] mmem [256];
  int          m_rd_free = 0;
  int          m_wr_left = 0;
  logic [7:0]  m_wr_addr = '0;
  bit          model_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic int eff(logic [3:0] bc);
    if (bc == 0) return 1;
    if (bc > 8) return 8;
    return int'(bc);
  endfunction

  function automatic void mwrite(logic [7:0] a, logic [31:0] d, logic [3:0] be);
`ifdef BURST_MEMORY_SLAVE_BYTEENABLE_EN
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mmem[a][b*8 +: 8] = d[b*8 +: 8];
    end
`else
    if (be == 4'hx) mmem[a] = 'x;
    mmem[a] = d;
`endif
  endfunction

  // Present one cycle of inputs and record what the memory must do in response.
  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [3:0] bc, input logic clr);
    int  c;
    int  n;
    bit  viol;
    c = cyc;
    viol = 1'b0;
    slave_read = rd;
    slave_write = wr;
    slave_address = a;
    slave_writedata = d;
    slave_byteenable = be;
    slave_burstcount = bc;
    control_clear_error = clr;
    if (c < m_rd_free) begin
      // stalled by an outstanding read burst
    end else if (m_wr_left > 0) begin
      if (wr) begin
        mwrite(m_wr_addr, d, be);
        m_wr_addr = m_wr_addr + 8'd1;
        m_wr_left--;
      end
      if (rd) viol = 1'b1;
    end else if (wr) begin
      n = eff(bc);
      mwrite(a, d, be);
      m_wr_left = n - 1;
      m_wr_addr = a + 8'd1;
      if (rd) viol = 1'b1;
    end else if (rd) begin
      n = eff(bc);
      for (int i = 0; i < n; i++) begin
        exp_valid[c+1+i] = 1'b1;
        exp_data[c+1+i] = mmem[8'(a + 8'(i))];
      end
      for (int i = 1; i < n; i++) exp_wait[c+i] = 1'b1;
      m_rd_free = c + n;
    end
    model_err = viol | (model_err & ~clr);
    exp_err[c+1] = model_err;
    exp_busy[c+1] = (m_wr_left > 0) || (c + 1 < m_rd_free);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'd1, 1'b0);
  endtask

  task automatic do_reset(input int k);
    int c;
    c = cyc;
    reset = 1'b1;
    slave_read = 1'b0;
    slave_write = 1'b0;
    control_clear_error = 1'b0;
    for (int i = c + 1; i < c + 40; i++) begin
      exp_valid[i] = 1'b0;
      exp_wait[i] = 1'b0;
      exp_busy[i] = 1'b0;
      exp_err[i] = 1'b0;
    end
    m_rd_free = 0;
    m_wr_left = 0;
    model_err = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("waitrequest", 32'(slave_waitrequest), reset ? 32'd1 : 32'(exp_wait[cyc]));
      chk("readdatavalid", 32'(slave_readdatavalid), 32'(exp_valid[cyc]));
      if (exp_valid[cyc]) chk("readdata", slave_readdata, exp_data[cyc]);
      chk("status_busy", 32'(status_busy), 32'(exp_busy[cyc]));
      chk("protocol_error", 32'(status_protocol_error), 32'(exp_err[cyc]));
    end
  end

  logic [31:0] burst_exp [4];
  logic [31:0] wrap_exp [3];
  int          cnt;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_waitrequest", 32'(slave_waitrequest), 32'd0);
    chk("reset_readdata", slave_readdata, 32'h0);
    chk("reset_busy", 32'(status_busy), 32'd0);

    // Single write then immediate read of the same word.
    drive(1'b0, 1'b1, 8'h03, 32'hA5A5A5A5, 4'hF, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 8'h03, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
    chk("single_rdv", 32'(slave_readdatavalid), 32'd1);
    chk("single_data", slave_readdata, 32'hA5A5A5A5);
    chk("single_wait", 32'(slave_waitrequest), 32'd0);
    idle();
    @(negedge clk);
    chk("single_rdv_off", 32'(slave_readdatavalid), 32'd0);

    // Write burst with a gap, address/burstcount garbage after beat 0.
    drive(1'b0, 1'b1, 8'h10, 32'd1, 4'hF, 4'd4, 1'b0);
    drive(1'b0, 1'b1, 8'hEE, 32'd2, 4'hF, 4'd9, 1'b0);
    idle();
    drive(1'b0, 1'b1, 8'hEE, 32'd3, 4'hF, 4'd9, 1'b0);
    drive(1'b0, 1'b1, 8'hEE, 32'd4, 4'hF, 4'd9, 1'b0);
    burst_exp = '{32'd1, 32'd2, 32'd3, 32'd4};
    drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 4'd4, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_rdv", 32'(slave_readdatavalid), 32'd1);
      chk("burst_data", slave_readdata, burst_exp[i]);
      chk("burst_busy", 32'(status_busy), (i < 3) ? 32'd1 : 32'd0);
      if (slave_waitrequest) cnt++;
      // A write held during the read burst is stalled, not an error.
      if (i == 0) drive(1'b0, 1'b1, 8'h10, 32'h99, 4'hF, 4'd1, 1'b0);
      else idle();
    end
    @(negedge clk);
    chk("burst_wait_cycles", 32'(cnt), 32'd3);
    chk("burst_rdv_off", 32'(slave_readdatavalid), 32'd0);
    chk("stall_no_error", 32'(status_protocol_error), 32'd0);

    // Wrap across the top of the address space.
    drive(1'b0, 1'b1, 8'hFF, 32'hC0, 4'hF, 4'd3, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 32'hC1, 4'hF, 4'd0, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 32'hC2, 4'hF, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
    chk("wrap_addr0", slave_readdata, 32'hC1);
    drive(1'b1, 1'b0, 8'h01, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
    chk("wrap_addr1", slave_readdata, 32'hC2);
    chk("b2b_rdv", 32'(slave_readdatavalid), 32'd1);
    wrap_exp = '{32'hC0, 32'hC1, 32'hC2};
    drive(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wrap_burst", slave_readdata, wrap_exp[i]);
      idle();
    end

    // Clamp: burstcount 12 becomes 8 beats for both write and read.
    drive(1'b0, 1'b1, 8'h40, 32'h100, 4'hF, 4'd12, 1'b0);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, 8'hEE, 32'h100 + 32'(i), 4'hF, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 8'h40, 32'h0, 4'h0, 4'd12, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (slave_readdatavalid) cnt++;
      idle();
    end
    chk("clamp_pulses", 32'(cnt), 32'd8);

    // burstcount 0 is a single beat.
    drive(1'b0, 1'b1, 8'h50, 32'h55, 4'hF, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 8'h50, 32'h0, 4'h0, 4'd0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (slave_readdatavalid) cnt++;
      idle();
    end
    chk("bc0_pulses", 32'(cnt), 32'd1);

    // Byte enables.
    drive(1'b0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 4'd1, 1'b0);
    drive(1'b0, 1'b1, 8'h20, 32'h11223344, 4'b0101, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 8'h20, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
`ifdef BURST_MEMORY_SLAVE_BYTEENABLE_EN
    chk("byteenable", slave_readdata, 32'hFF22FF44);
`else
    chk("byteenable", slave_readdata, 32'h11223344);
`endif

    // Read and write together in idle: write wins, error set, then cleared.
    drive(1'b1, 1'b1, 8'h30, 32'hDEAD0030, 4'hF, 4'd1, 1'b0);
    @(negedge clk);
    chk("rw_error", 32'(status_protocol_error), 32'd1);
    chk("rw_no_rdv", 32'(slave_readdatavalid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'd1, 1'b1);
    @(negedge clk);
    chk("clear_error", 32'(status_protocol_error), 32'd0);
    drive(1'b1, 1'b0, 8'h30, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
    chk("rw_write_done", slave_readdata, 32'hDEAD0030);

    // Read during a write burst with clear in the same cycle: violation wins.
    drive(1'b0, 1'b1, 8'h60, 32'h61, 4'hF, 4'd2, 1'b0);
    drive(1'b1, 1'b1, 8'hEE, 32'h62, 4'hF, 4'd0, 1'b1);
    @(negedge clk);
    chk("violation_beats_clear", 32'(status_protocol_error), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'd1, 1'b1);
    drive(1'b1, 1'b0, 8'h60, 32'h0, 4'h0, 4'd2, 1'b0);
    idle();
    @(negedge clk);
    chk("write_burst_beat1", slave_readdata, 32'h62);
    idle();

    // Reset in the middle of a read burst.
    drive(1'b1, 1'b0, 8'h40, 32'h0, 4'h0, 4'd8, 1'b0);
    idle();
    idle();
    do_reset(2);
    @(negedge clk);
    chk("post_reset_wait", 32'(slave_waitrequest), 32'd0);
    chk("post_reset_rdv", 32'(slave_readdatavalid), 32'd0);
    chk("post_reset_data", slave_readdata, 32'h0);
    drive(1'b1, 1'b0, 8'h43, 32'h0, 4'h0, 4'd1, 1'b0);
    @(negedge clk);
    chk("post_reset_read", slave_readdata, 32'h103);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
